// File: rtl/stage_a.sv
// stage_a -- input stage of a DSP slice: A/B/D/C/opmode/carry pipeline
// registers, an optional D+/-B pre-adder, an unsigned 18x18 multiplier
// and the X/Z operand muxes feeding the downstream add/sub stage.
//
// Build option: define STAGE_A_PREADD_EN to include the pre-adder
// (opmode[4] enables it, opmode[6] selects D-B instead of D+B).
// Without it, B1 always takes the B0 value. The D register and D port
// stay in place because the X mux concat still uses them.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears all regs)
//   A, B, D           18-bit operands (B/D also feed the pre-adder)
//   C, PCIN, P        48-bit Z-mux sources (P also feeds the X mux)
//   CARRYIN           external carry
//   opmode            mode word: [1:0] X sel, [3:2] Z sel, [4] pre-add,
//                     [5] carry, [6] pre-sub, [7] add/sub downstream
//   CE*               per-register clock enables
//   outOfX, outOfZ    X/Z operands to the downstream stage
//   outOfCYI          carry-in to the downstream stage
//   opmode_out        registered/bypassed opmode
//   M_out             multiplier result
//   BCOUT             B1-stage value
module stage_a #(
  parameter int unsigned A0REG      = 0,
  parameter int unsigned A1REG      = 1,
  parameter int unsigned B0REG      = 0,
  parameter int unsigned B1REG      = 1,
  parameter int unsigned CREG       = 1,
  parameter int unsigned DREG       = 1,
  parameter int unsigned MREG       = 1,
  parameter int unsigned OPMODEREG  = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter string       CARRYINSEL = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic [47:0] P,
  input  logic        CARRYIN,
  input  logic [7:0]  opmode,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  output logic [47:0] outOfX,
  output logic [47:0] outOfZ,
  output logic        outOfCYI,
  output logic [7:0]  opmode_out,
  output logic [35:0] M_out,
  output logic [17:0] BCOUT
);

  // Carry source decode: 1 = opmode[5], 2 = CARRYIN, 0 = constant 0.
  localparam logic [1:0] CY_SRC = (CARRYINSEL == "OPMODE5") ? 2'd1 :
                                  (CARRYINSEL == "CARRYIN") ? 2'd2 : 2'd0;

  logic [17:0] a0_q, a1_q, b0_q, b1_q, d_q;
  logic [47:0] c_q;
  logic [35:0] m_q;
  logic [7:0]  op_q;
  logic        cy_q;

  // Stage values: register output when the stage is enabled, else its input.
  logic [17:0] a0_v, a1_v, b0_v, b1_v, d_v;
  logic [47:0] c_v;
  logic [35:0] m_v;
  logic [7:0]  op_v;
  logic        cy_v;

  logic [17:0] b1_d;
  logic [35:0] m_d;
  logic        cy_d;

  always_comb begin
    a0_v = (A0REG      != 0) ? a0_q : A;
    a1_v = (A1REG      != 0) ? a1_q : a0_v;
    b0_v = (B0REG      != 0) ? b0_q : B;
    d_v  = (DREG       != 0) ? d_q  : D;
    c_v  = (CREG       != 0) ? c_q  : C;
    op_v = (OPMODEREG  != 0) ? op_q : opmode;
  end

  // Pre-adder select comes from the post-register opmode like every other mux.
  always_comb begin
    b1_d = b0_v;
`ifdef STAGE_A_PREADD_EN
    if (op_v[4]) begin
      b1_d = op_v[6] ? (d_v - b0_v) : (d_v + b0_v);
    end
`endif
  end

  always_comb begin
    b1_v = (B1REG != 0) ? b1_q : b1_d;
    m_d  = {18'b0, a1_v} * {18'b0, b1_v};
    m_v  = (MREG != 0) ? m_q : m_d;
  end

  always_comb begin
    cy_d = 1'b0;
    case (CY_SRC)
      2'd1:    cy_d = op_v[5];
      2'd2:    cy_d = CARRYIN;
      default: cy_d = 1'b0;
    endcase
    cy_v = (CARRYINREG != 0) ? cy_q : cy_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      d_q  <= '0;
      c_q  <= '0;
      m_q  <= '0;
      op_q <= '0;
      cy_q <= 1'b0;
    end else begin
      if (CEA) begin
        a0_q <= A;
        a1_q <= a0_v;
      end
      if (CEB) begin
        b0_q <= B;
        b1_q <= b1_d;
      end
      if (CED)       d_q  <= D;
      if (CEC)       c_q  <= C;
      if (CEM)       m_q  <= m_d;
      if (CEOPMODE)  op_q <= opmode;
      if (CECARRYIN) cy_q <= cy_d;
    end
  end

  always_comb begin
    outOfX = '0;
    case (op_v[1:0])
      2'd0:    outOfX = '0;
      2'd1:    outOfX = {12'b0, m_v};
      2'd2:    outOfX = P;
      default: outOfX = {d_v[11:0], a1_v, b1_v};
    endcase
  end

  always_comb begin
    outOfZ = '0;
    case (op_v[3:2])
      2'd0:    outOfZ = '0;
      2'd1:    outOfZ = PCIN;
      2'd2:    outOfZ = P;
      default: outOfZ = c_v;
    endcase
  end

  assign outOfCYI   = cy_v;
  assign opmode_out = op_v;
  assign M_out      = m_v;
  assign BCOUT      = b1_v;

endmodule

// File: tb/tb_stage_a.sv
module tb_stage_a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [17:0] A, B, D;
  logic [47:0] C, PCIN, P;
  logic        CARRYIN;
  logic [7:0]  opmode;
  logic        CEA, CEB, CEC, CED, CEM, CEOPMODE, CECARRYIN;

  logic [47:0] x0, z0, x1, z1;
  logic        cy0, cy1;
  logic [7:0]  op0, op1;
  logic [35:0] m0, m1;
  logic [17:0] bc0, bc1;

  int checks = 0;
  int passed = 0;
  logic [47:0] exp_q[$];
  logic [47:0] e;

  // Default configuration.
  stage_a u_dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .P(P),
    .CARRYIN(CARRYIN), .opmode(opmode),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .outOfX(x0), .outOfZ(z0), .outOfCYI(cy0), .opmode_out(op0),
    .M_out(m0), .BCOUT(bc0)
  );

  // External carry source, C and M stages bypassed.
  stage_a #(.CARRYINSEL("CARRYIN"), .CREG(0), .MREG(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .P(P),
    .CARRYIN(CARRYIN), .opmode(opmode),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .outOfX(x1), .outOfZ(z1), .outOfCYI(cy1), .opmode_out(op1),
    .M_out(m1), .BCOUT(bc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEC = v; CED = v; CEM = v; CEOPMODE = v; CECARRYIN = v;
  endtask

  task automatic test_reset;
    set_ce(1'b1);
    rst_n = 1'b0;
    A = 18'h155; B = 18'h2AA; D = 18'h3F0; C = 48'hA5A5_A5A5_A5A5;
    P = 48'h1111_2222_3333; PCIN = 48'h4444_5555_6666;
    opmode = 8'hFF; CARRYIN = 1'b1;
    tick;
    checks++; if (x0 !== 48'h0) $display("FAIL reset_x got %h exp 0", x0); else passed++;
    checks++; if (z0 !== 48'h0) $display("FAIL reset_z got %h exp 0", z0); else passed++;
    checks++; if (cy0 !== 1'b0) $display("FAIL reset_cyi got %b exp 0", cy0); else passed++;
    checks++; if (op0 !== 8'h0) $display("FAIL reset_opmode got %h exp 0", op0); else passed++;
    checks++; if (m0 !== 36'h0) $display("FAIL reset_m got %h exp 0", m0); else passed++;
    checks++; if (bc0 !== 18'h0) $display("FAIL reset_bcout got %h exp 0", bc0); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_mult_latency;
    opmode = 8'h01; A = '0; B = '0; D = '0; CARRYIN = 1'b0;
    tick;
    tick;
    A = 18'd3; B = 18'd5;
    exp_q.push_back(48'd15);
    tick;
    checks++; if (x0 !== 48'd0) $display("FAIL lat_x_early got %h exp 0", x0); else passed++;
    checks++; if (m1 !== 36'd15) $display("FAIL lat_m_bypass got %h exp f", m1); else passed++;
    tick;
    e = exp_q.pop_front();
    checks++; if (x0 !== e) $display("FAIL lat_x got %h exp %h", x0, e); else passed++;
    checks++; if (m0 !== e[35:0]) $display("FAIL lat_m got %h exp %h", m0, e[35:0]); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [17:0] a, b;
    opmode = 8'h01;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a = 18'($urandom_range(0, 18'h3FFFF));
        b = 18'($urandom_range(0, 18'h3FFFF));
        A = a; B = b;
        exp_q.push_back({12'b0, {18'b0, a} * {18'b0, b}});
      end
      tick;
      if (i >= 1) begin
        e = exp_q.pop_front();
        checks++; if (x0 !== e) $display("FAIL b2b_x[%0d] got %h exp %h", i - 1, x0, e); else passed++;
      end
    end
  endtask

  task automatic test_xz_mux;
    logic [17:0] d, a, b;
    d = 18'h2ABCD; a = 18'h01234; b = 18'h3ABC5;
    opmode = 8'h03; D = d; A = a; B = b;
    exp_q.push_back({d[11:0], a, b});
    tick; tick;
    e = exp_q.pop_front();
    checks++; if (x0 !== e) $display("FAIL x_concat got %h exp %h", x0, e); else passed++;
    P = 48'hDEAD_BEEF_0001; opmode = 8'h02;
    tick;
    checks++; if (x0 !== 48'hDEAD_BEEF_0001) $display("FAIL x_p got %h exp deadbeef0001", x0); else passed++;
    opmode = 8'h00;
    tick;
    checks++; if (x0 !== 48'h0) $display("FAIL x_zero got %h exp 0", x0); else passed++;
    PCIN = 48'h0F0F_1234_5678; opmode = 8'h04;
    tick;
    checks++; if (z0 !== 48'h0F0F_1234_5678) $display("FAIL z_pcin got %h exp 0f0f12345678", z0); else passed++;
    opmode = 8'h08;
    tick;
    checks++; if (z0 !== 48'hDEAD_BEEF_0001) $display("FAIL z_p got %h exp deadbeef0001", z0); else passed++;
  endtask

  task automatic test_creg_hold;
    C = 48'h1234_5678_9ABC; opmode = 8'h0C;
    tick;
    checks++; if (z0 !== 48'h1234_5678_9ABC) $display("FAIL c_load got %h exp 123456789abc", z0); else passed++;
    checks++; if (z1 !== 48'h1234_5678_9ABC) $display("FAIL c_bypass got %h exp 123456789abc", z1); else passed++;
    CEC = 1'b0; C = 48'hFFFF_0000_1111;
    tick;
    checks++; if (z0 !== 48'h1234_5678_9ABC) $display("FAIL c_hold got %h exp 123456789abc", z0); else passed++;
    checks++; if (z1 !== 48'hFFFF_0000_1111) $display("FAIL c_bypass_ce got %h exp ffff00001111", z1); else passed++;
    CEC = 1'b1;
    CEOPMODE = 1'b0; opmode = 8'h00;
    tick;
    checks++; if (op0 !== 8'h0C) $display("FAIL opmode_hold got %h exp 0c", op0); else passed++;
    CEOPMODE = 1'b1;
  endtask

  task automatic test_ce_hold;
    opmode = 8'h01; A = 18'd7; B = 18'd9;
    tick; tick; tick;
    set_ce(1'b0);
    A = 18'd1; B = 18'd1;
    tick; tick;
    checks++; if (m0 !== 36'd63) $display("FAIL ce_hold_m got %0d exp 63", m0); else passed++;
    checks++; if (bc0 !== 18'd9) $display("FAIL ce_hold_b got %0d exp 9", bc0); else passed++;
    set_ce(1'b1);
    tick; tick;
    checks++; if (m0 !== 36'd1) $display("FAIL ce_resume_m got %0d exp 1", m0); else passed++;
  endtask

  task automatic test_carry;
    CARRYIN = 1'b0; opmode = 8'h00;
    tick; tick;
    CARRYIN = 1'b1;
    tick;
    checks++; if (cy1 !== 1'b1) $display("FAIL cy_carryin got %b exp 1", cy1); else passed++;
    checks++; if (cy0 !== 1'b0) $display("FAIL cy_opmode5_off got %b exp 0", cy0); else passed++;
    CARRYIN = 1'b0; opmode = 8'h20;
    tick;
    checks++; if (cy0 !== 1'b0) $display("FAIL cy_opmode5_early got %b exp 0", cy0); else passed++;
    tick;
    checks++; if (cy0 !== 1'b1) $display("FAIL cy_opmode5 got %b exp 1", cy0); else passed++;
    checks++; if (cy1 !== 1'b0) $display("FAIL cy_carryin_off got %b exp 0", cy1); else passed++;
  endtask

  task automatic test_preadd;
    D = 18'd10; B = 18'd4; A = 18'd2; opmode = 8'h51;
`ifdef STAGE_A_PREADD_EN
    exp_q.push_back(48'd12);
`else
    exp_q.push_back(48'd8);
`endif
    tick; tick; tick;
    e = exp_q.pop_front();
    checks++; if (m0 !== e[35:0]) $display("FAIL preadd_sub got %0d exp %0d", m0, e[35:0]); else passed++;
    opmode = 8'h11;
`ifdef STAGE_A_PREADD_EN
    exp_q.push_back(48'd28);
`else
    exp_q.push_back(48'd8);
`endif
    tick; tick; tick;
    e = exp_q.pop_front();
    checks++; if (m0 !== e[35:0]) $display("FAIL preadd_add got %0d exp %0d", m0, e[35:0]); else passed++;
    D = 18'd0; B = 18'd1; opmode = 8'h51;
`ifdef STAGE_A_PREADD_EN
    exp_q.push_back(48'h3FFFF);
`else
    exp_q.push_back(48'h1);
`endif
    tick; tick;
    e = exp_q.pop_front();
    checks++; if (bc0 !== e[17:0]) $display("FAIL preadd_wrap got %h exp %h", bc0, e[17:0]); else passed++;
  endtask

  task automatic test_mid_reset;
    opmode = 8'h01; D = '0; A = 18'd5; B = 18'd6;
    tick;
    set_ce(1'b0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (m0 !== 36'd0) $display("FAIL midrst_m got %0d exp 0", m0); else passed++;
    checks++; if (bc0 !== 18'd0) $display("FAIL midrst_b got %0d exp 0", bc0); else passed++;
    checks++; if (op0 !== 8'd0) $display("FAIL midrst_op got %h exp 0", op0); else passed++;
    checks++; if (x0 !== 48'd0) $display("FAIL midrst_x got %h exp 0", x0); else passed++;
    set_ce(1'b1);
    tick;
    checks++; if (m0 !== 36'd0) $display("FAIL midrst_flush got %0d exp 0", m0); else passed++;
    tick;
    checks++; if (x0 !== 48'd30) $display("FAIL midrst_reload got %0d exp 30", x0); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    A = '0; B = '0; D = '0; C = '0; PCIN = '0; P = '0;
    CARRYIN = 1'b0; opmode = '0;
    set_ce(1'b1);
    #1;
    test_reset;
    test_mult_latency;
    test_back_to_back;
    test_xz_mux;
    test_creg_hold;
    test_ce_hold;
    test_carry;
    test_preadd;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
